// File: rtl/core_pkg.sv
// Shared definitions for the commit stage: branch condition codes, flag bit
// positions within {S,Z,C,V}, and the commit state encoding.
package core_pkg;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } commit_state_e;

endpackage

// File: rtl/cond_eval.sv
// Conditional-branch resolver: evaluates a 3-bit condition code against the
// architectural {S,Z,C,V} flags. Codes 100-111 are never taken.
module cond_eval
    import core_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic s_xor_v;
    logic unused_c;

    assign s_xor_v  = flags[FLAG_S] ^ flags[FLAG_V];
    // No condition in this ISA looks at carry.
    assign unused_c = flags[FLAG_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = flags[FLAG_Z];
            COND_BLT: taken = s_xor_v;
            COND_BLE: taken = flags[FLAG_Z] | s_xor_v;
            COND_BNE: taken = ~flags[FLAG_Z];
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_commit_stage.sv
// Commit/writeback stage: writes the register file, owns the SZCV flags,
// resolves branches, squashes wrong-path instructions and counts retirements.
module ex_commit_stage
    import core_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int RA_W         = 3,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] ex_result,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_rf_we,
    input  logic             ex_flag_we,
    input  logic             ex_s,
    input  logic             ex_z,
    input  logic             ex_c,
    input  logic             ex_v,
    input  logic             ex_is_b,
    input  logic             ex_is_bcc,
    input  logic [2:0]       ex_cond,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [3:0]       flags,
    output logic [15:0]      instret
);

    // Keep the counter at least one bit wide so SQUASH_DEPTH=0 still elaborates.
    localparam int SQ_W = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;

    commit_state_e    state, state_nxt;
    logic [SQ_W-1:0]  sq_cnt, sq_cnt_nxt;
    logic             accept;
    logic             commit;
    logic             cond_taken;
    logic             taken;

    logic             rf_we_p1;
    logic [RA_W-1:0]  rf_waddr_p1;
    logic [WIDTH-1:0] rf_wdata_p1;
    logic             redirect_vld_p1;
    logic [WIDTH-1:0] redirect_pc_p1;
    logic [3:0]       flags_q;
    logic [15:0]      instret_q;

    assign ex_ready = rst_n & ~hold;
    assign accept   = ex_valid & ex_ready;
    assign commit   = accept & (state == ST_RUN);

    // Resolved against the flags register before this edge; a flag writer in the
    // previous cycle has already landed, so no bypass path exists.
    cond_eval u_cond_eval (
        .flags (flags_q),
        .cond  (ex_cond),
        .taken (cond_taken)
    );

    assign taken = ex_is_b | (ex_is_bcc & cond_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sq_cnt_nxt = sq_cnt;
        case (state)
            ST_RUN: begin
                if (commit && taken && (SQUASH_DEPTH > 0)) begin
                    state_nxt  = ST_SQUASH;
                    sq_cnt_nxt = SQ_W'(SQUASH_DEPTH);
                end
            end
            ST_SQUASH: begin
                if (accept) begin
                    sq_cnt_nxt = sq_cnt - SQ_W'(1);
                    if (sq_cnt == SQ_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt  = ST_RUN;
                sq_cnt_nxt = '0;
            end
        endcase
    end

    // ---- commit edge: writeback/redirect strobes and architectural state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_p1        <= 1'b0;
            rf_waddr_p1     <= '0;
            rf_wdata_p1     <= '0;
            redirect_vld_p1 <= 1'b0;
            redirect_pc_p1  <= '0;
            flags_q         <= 4'b0000;
            instret_q       <= 16'h0000;
        end else begin
            rf_we_p1        <= commit & ex_rf_we;
            redirect_vld_p1 <= commit & taken;
            if (commit && ex_rf_we) begin
                rf_waddr_p1 <= ex_rd;
                rf_wdata_p1 <= ex_result;
            end
            if (commit && taken) begin
                redirect_pc_p1 <= ex_result;
            end
            if (commit && ex_flag_we) begin
                flags_q <= {ex_s, ex_z, ex_c, ex_v};
            end
            if (commit) begin
                instret_q <= instret_q + 16'd1;
            end
        end
    end

    assign rf_we          = rf_we_p1;
    assign rf_waddr       = rf_waddr_p1;
    assign rf_wdata       = rf_wdata_p1;
    assign redirect_valid = redirect_vld_p1;
    assign redirect_pc    = redirect_pc_p1;
    assign flags          = flags_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_ex_commit_stage.sv
// Bench for ex_commit_stage: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of commit, branch and squash rules.
module tb_ex_commit_stage;

    localparam int WIDTH = 16;
    localparam int RA_W  = 3;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hold;
    logic             ex_valid;
    logic             ex_ready;
    logic [WIDTH-1:0] ex_result;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_rf_we;
    logic             ex_flag_we;
    logic             ex_s, ex_z, ex_c, ex_v;
    logic             ex_is_b;
    logic             ex_is_bcc;
    logic [2:0]       ex_cond;
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic [3:0]       flags;
    logic [15:0]      instret;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_sq_left;
    logic [3:0]  m_flags;
    logic [15:0] m_instret;
    logic        m_rf_we;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata;
    logic        m_rv;
    logic [15:0] m_rpc;

    ex_commit_stage #(
        .WIDTH        (WIDTH),
        .RA_W         (RA_W),
        .SQUASH_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_result      (ex_result),
        .ex_rd          (ex_rd),
        .ex_rf_we       (ex_rf_we),
        .ex_flag_we     (ex_flag_we),
        .ex_s           (ex_s),
        .ex_z           (ex_z),
        .ex_c           (ex_c),
        .ex_v           (ex_v),
        .ex_is_b        (ex_is_b),
        .ex_is_bcc      (ex_is_bcc),
        .ex_cond        (ex_cond),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flags          (flags),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_true(input logic [3:0] f, input logic [2:0] c);
        logic s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        if (c == 3'd0) return z;
        if (c == 3'd1) return s != v;
        if (c == 3'd2) return z || (s != v);
        if (c == 3'd3) return !z;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_sq_left = 0;
        m_flags   = 4'b0;
        m_instret = 16'h0;
        m_rf_we   = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
        m_rv      = 1'b0;
        m_rpc     = '0;
    endtask

    // Predict what one clock edge does with the inputs currently driven.
    task automatic model_step();
        logic tk;
        m_rf_we = 1'b0;
        m_rv    = 1'b0;
        if (ex_valid && !hold) begin
            if (m_sq_left > 0) begin
                m_sq_left--;
            end else begin
                tk = ex_is_b || (ex_is_bcc && cond_true(m_flags, ex_cond));
                if (ex_rf_we) begin
                    m_rf_we = 1'b1;
                    m_waddr = ex_rd;
                    m_wdata = ex_result;
                end
                if (tk) begin
                    m_rv      = 1'b1;
                    m_rpc     = ex_result;
                    m_sq_left = DEPTH;
                end
                if (ex_flag_we) m_flags = {ex_s, ex_z, ex_c, ex_v};
                m_instret = m_instret + 16'd1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("rf_we",          32'(rf_we),          32'(m_rf_we));
        chk("rf_waddr",       32'(rf_waddr),       32'(m_waddr));
        chk("rf_wdata",       32'(rf_wdata),       32'(m_wdata));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        chk("redirect_pc",    32'(redirect_pc),    32'(m_rpc));
        chk("flags",          32'(flags),          32'(m_flags));
        chk("instret",        32'(instret),        32'(m_instret));
    endtask

    task automatic cycle(input logic v, input logic h, input logic [15:0] res,
                         input logic [2:0] rd, input logic we, input logic fwe,
                         input logic [3:0] szcv, input logic b, input logic bcc,
                         input logic [2:0] cond);
        @(negedge clk);
        ex_valid   = v;
        hold       = h;
        ex_result  = res;
        ex_rd      = rd;
        ex_rf_we   = we;
        ex_flag_we = fwe;
        {ex_s, ex_z, ex_c, ex_v} = szcv;
        ex_is_b    = b;
        ex_is_bcc  = bcc;
        ex_cond    = cond;
        #1;
        chk("ex_ready", 32'(ex_ready), 32'(!h));
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        ex_valid = 0; hold = 0; ex_result = '0; ex_rd = '0; ex_rf_we = 0;
        ex_flag_we = 0; {ex_s, ex_z, ex_c, ex_v} = 4'b0; ex_is_b = 0;
        ex_is_bcc = 0; ex_cond = 3'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},   32'(ex_ready),       32'd0);
        chk({tag, "_rf_we"},   32'(rf_we),          32'd0);
        chk({tag, "_waddr"},   32'(rf_waddr),       32'd0);
        chk({tag, "_wdata"},   32'(rf_wdata),       32'd0);
        chk({tag, "_rv"},      32'(redirect_valid), 32'd0);
        chk({tag, "_rpc"},     32'(redirect_pc),    32'd0);
        chk({tag, "_flags"},   32'(flags),          32'd0);
        chk({tag, "_instret"}, 32'(instret),        32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LI commit
        cycle(1, 0, 16'h1234, 3'd3, 1, 0, 4'b0000, 0, 0, 3'd0);
        chk("li_wdata", 32'(rf_wdata), 32'h1234);
        chk("li_waddr", 32'(rf_waddr), 32'd3);
        chk("li_instret", 32'(instret), 32'd1);

        // ADDI setting Z, then BE taken
        cycle(1, 0, 16'h0000, 3'd1, 1, 1, 4'b0100, 0, 0, 3'd0);
        cycle(1, 0, 16'h0040, 3'd0, 0, 0, 4'b0000, 0, 1, 3'd0);
        chk("be_redirect", 32'(redirect_valid), 32'd1);
        chk("be_pc", 32'(redirect_pc), 32'h0040);
        chk("be_flags", 32'(flags), 32'b0100);
        cycle(0, 0, 16'h0, 3'd0, 0, 0, 4'b0000, 0, 0, 3'd0);
        chk("be_pulse_end", 32'(redirect_valid), 32'd0);

        // Two squashed, third commits
        cycle(1, 0, 16'h1111, 3'd2, 1, 1, 4'b1111, 0, 0, 3'd0);
        chk("sq1_rf_we", 32'(rf_we), 32'd0);
        cycle(1, 0, 16'h2222, 3'd4, 1, 0, 4'b0000, 1, 0, 3'd0);
        chk("sq2_rv", 32'(redirect_valid), 32'd0);
        cycle(1, 0, 16'h00AA, 3'd5, 1, 0, 4'b0000, 0, 0, 3'd0);
        chk("post_sq_wdata", 32'(rf_wdata), 32'h00AA);
        chk("post_sq_instret", 32'(instret), 32'd4);

        // Hold during squash
        cycle(1, 0, 16'h0100, 3'd0, 0, 0, 4'b0000, 1, 0, 3'd0);
        repeat (3) cycle(1, 1, 16'h3333, 3'd6, 1, 0, 4'b0000, 0, 0, 3'd0);
        cycle(1, 0, 16'h4444, 3'd6, 1, 0, 4'b0000, 0, 0, 3'd0);
        cycle(1, 0, 16'h5555, 3'd6, 1, 0, 4'b0000, 0, 0, 3'd0);
        chk("hold_sq_rf_we", 32'(rf_we), 32'd0);
        cycle(1, 0, 16'h6666, 3'd7, 1, 0, 4'b0000, 0, 0, 3'd0);
        chk("hold_post_wdata", 32'(rf_wdata), 32'h6666);

        // Not taken: Z=0 with BE, and reserved code 110
        cycle(1, 0, 16'h0000, 3'd1, 0, 1, 4'b0000, 0, 0, 3'd0);
        cycle(1, 0, 16'h0080, 3'd0, 0, 0, 4'b0000, 0, 1, 3'd0);
        chk("nt_be", 32'(redirect_valid), 32'd0);
        cycle(1, 0, 16'h0090, 3'd0, 0, 0, 4'b0000, 0, 1, 3'd6);
        cycle(1, 0, 16'h0077, 3'd2, 1, 0, 4'b0000, 0, 0, 3'd0);
        chk("nt_no_squash", 32'(rf_we), 32'd1);

        // Reset in the middle of a squash window
        cycle(1, 0, 16'h0200, 3'd0, 0, 0, 4'b0000, 1, 0, 3'd0);
        cycle(1, 0, 16'h7777, 3'd3, 1, 0, 4'b0000, 0, 0, 3'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 16'h0BEE, 3'd5, 1, 0, 4'b0000, 0, 0, 3'd0);
        chk("after_rst_rf_we", 32'(rf_we), 32'd1);
        chk("after_rst_instret", 32'(instret), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic v, h, we, fwe, b, bcc;
            logic [3:0] szcv;
            v    = ($urandom_range(0, 9) < 7);
            h    = ($urandom_range(0, 9) < 2);
            we   = $urandom_range(0, 1);
            fwe  = $urandom_range(0, 1);
            b    = ($urandom_range(0, 9) == 0);
            bcc  = ($urandom_range(0, 9) < 2);
            szcv = 4'($urandom);
            cycle(v, h, 16'($urandom), 3'($urandom), we, fwe, szcv, b, bcc, 3'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_commit_stage.md
# ex_commit_stage

Commit/writeback stage downstream of the LI/ADDI/SUBI/branch execute unit in the 16-bit core. It latches one execute result per cycle, writes the register file, updates the architectural SZCV flag register, resolves unconditional and conditional branches against those flags, and squashes wrong-path instructions after a taken branch. It also keeps a committed-instruction counter.

## Interface
- `WIDTH`, 16, datapath width
- `RA_W`, 3, register address width
- `SQUASH_DEPTH`, 2, wrong-path instructions discarded after a taken branch (0 allowed)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `hold`  in  1  global stall
- `ex_valid`  in  1  execute result present
- `ex_ready`  out  1  stage accepts this cycle
- `ex_result`  in  WIDTH  ALU result; branch target for branches
- `ex_rd`  in  RA_W  destination register
- `ex_rf_we`  in  1  result writes register file
- `ex_flag_we`  in  1  instruction writes flags
- `ex_s`, `ex_z`, `ex_c`, `ex_v`  in  1 each  execute flags
- `ex_is_b`  in  1  unconditional branch
- `ex_is_bcc`  in  1  conditional branch
- `ex_cond`  in  3  branch condition
- `rf_we`  out  1  register write strobe
- `rf_waddr`  out  RA_W  register write address
- `rf_wdata`  out  WIDTH  register write data
- `redirect_valid`  out  1  fetch redirect pulse
- `redirect_pc`  out  WIDTH  redirect target
- `flags`  out  4  architectural {S,Z,C,V}
- `instret`  out  16  committed instruction count

## Operation
- Accept = `ex_valid & ex_ready`; `ex_ready = rst_n & ~hold`.
- States: RUN, SQUASH. Squash counter `sq_cnt`, width clog2(SQUASH_DEPTH+1).
- RUN, accepted instruction commits:
  - `ex_rf_we` → register write.
  - `ex_flag_we` → flags <= {ex_s,ex_z,ex_c,ex_v}.
  - `instret` += 1, wraps 0xFFFF→0x0000.
- Branch taken if `ex_is_b`, or `ex_is_bcc` with condition true on the *current* flags register (value before this edge):
  - 000 BE = Z
  - 001 BLT = S^V
  - 010 BLE = Z|(S^V)
  - 011 BNE = ~Z
  - 100–111 never taken
- Taken branch: `redirect_pc` <= `ex_result`, `redirect_valid` pulses.
  - SQUASH_DEPTH>0: go to SQUASH, `sq_cnt` <= SQUASH_DEPTH.
  - SQUASH_DEPTH=0: stay in RUN.
- SQUASH: each accepted instruction is discarded (no rf write, flag write, redirect, or instret increment); `sq_cnt` decrements; 1→0 returns to RUN. Branches in the squash window are ignored.
- Flag-writing instruction immediately before a bcc: its flags are already in the register when the bcc is accepted (one-cycle-earlier edge). No bypass needed.
- Both `ex_is_b` and `ex_is_bcc` set: treat as unconditional.
- `ex_rf_we` on a branch: register write also performed (link semantics belong to execute).

## Timing
- Latency 1: accept at edge N → `rf_we`/`rf_waddr`/`rf_wdata`/`redirect_*` valid during cycle N+1; `flags`/`instret` updated at edge N.
- `rf_we` and `redirect_valid` are single-cycle pulses. They are 0 on any cycle with no commit, including during `hold`.
- `rf_waddr`, `rf_wdata`, and `redirect_pc` hold their last values when not strobed.
- `hold` freezes state, `sq_cnt`, flags, and instret. Held cycles are not counted toward squash.
- Reset (anytime, including mid-SQUASH): state RUN, `sq_cnt` 0. All outputs are 0: `rf_*`, `redirect_*`, `flags`, `instret`, `ex_ready`.

## Structure
- Shared package `core_pkg`: condition-code constants (COND_BE..COND_BNE), commit state enum, flag bit indices (FLAG_S=3, Z=2, C=1, V=0).
- One sub-module `cond_eval`: combinational, `flags` + `ex_cond` → `taken`.

## Test plan
- LI commit: accept rd=3, result 0x1234, rf_we=1 → next cycle rf_we=1, waddr=3, wdata=0x1234; instret 0→1.
- Flags + BE: ADDI flag_we with Z=1, then bcc cond=000, result 0x0040 → redirect_valid one cycle with redirect_pc=0x0040; flags=0b0100.
- Squash: after the taken branch, two accepted rf_we instructions → no rf_we, instret unchanged. Third instruction (rd=5, 0x00AA) commits normally.
- Hold during SQUASH: hold=1 for 3 cycles with ex_valid=1 → ex_ready=0, sq_cnt frozen. After release, exactly 2 further instructions are squashed.
- Not taken: Z=0, bcc cond=000; also cond=110 → no redirect, no squash, instret increments.
- Reset mid-SQUASH: assert rst_n=0 with sq_cnt=1 → immediately all outputs 0, RUN. First instruction after release commits.
